// File: rtl/ifetch_sa.sv
// Instruction fetch unit: N-way set-associative I-cache, bimodal branch predictor, refill FSM.
// Define IFETCH_PERF_EN to add the hit_cnt/miss_cnt/redirect_cnt performance counter ports.
module ifetch_sa #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 16,
  parameter int unsigned LINE_WORDS  = 16,
  parameter int unsigned BHT_ENTRIES = 1024,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic                     pred_taken,
  input  logic                     stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_resp_valid,
  input  logic [LINE_WORDS*32-1:0] mem_resp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     upd_valid,
  input  logic [31:0]              upd_pc,
  input  logic                     upd_taken
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt,
  output logic [31:0]              redirect_cnt
`endif
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BHT_W  = $clog2(BHT_ENTRIES);

  typedef enum logic {StIdle, StWait} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              pc_q;
  logic [LINE_WORDS*32-1:0] data_q  [WAYS][SETS];
  logic [TAG_W-1:0]         tag_q   [WAYS][SETS];
  logic [WAYS-1:0]          valid_q [SETS];
  logic [WAY_W-1:0]         rr_q    [SETS];
  logic [1:0]               bht_q   [BHT_ENTRIES];

  logic [IDX_W-1:0]         idx, fill_idx;
  logic [TAG_W-1:0]         tag, fill_tag;
  logic [WORD_W-1:0]        woff;
  logic                     hit;
  logic [LINE_WORDS*32-1:0] hit_line;
  logic [31:0]              fetch_word, j_imm, b_imm, pred_pc;
  logic [1:0]               bht_rd;
  logic                     pred_tk, issue, miss_start, fill;
  logic [WAY_W-1:0]         victim;
  logic [BHT_W-1:0]         upd_idx;
  logic                     unused_upd;

  assign idx      = pc_q[OFF_W +: IDX_W];
  assign tag      = pc_q[31 -: TAG_W];
  assign woff     = pc_q[2 +: WORD_W];
  assign fill_idx = mem_addr[OFF_W +: IDX_W];
  assign fill_tag = mem_addr[31 -: TAG_W];
  assign upd_idx  = upd_pc[2 +: BHT_W];
  assign unused_upd = ^{upd_pc[31:BHT_W+2], upd_pc[1:0]};

  // Lookup reads registered arrays, so a same-cycle fill is only visible next cycle.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
        hit      = 1'b1;
        hit_line = data_q[w][idx];
      end
    end
  end

  assign fetch_word = hit_line[32*woff +: 32];
  assign j_imm  = {{12{fetch_word[31]}}, fetch_word[19:12], fetch_word[20],
                   fetch_word[30:21], 1'b0};
  assign b_imm  = {{20{fetch_word[31]}}, fetch_word[7], fetch_word[30:25],
                   fetch_word[11:8], 1'b0};
  assign bht_rd = bht_q[pc_q[2 +: BHT_W]];

  always_comb begin
    pred_pc = pc_q + 32'd4;
    pred_tk = 1'b0;
    if (fetch_word[6:0] == 7'b1101111) begin
      pred_tk = 1'b1;
      pred_pc = pc_q + j_imm;
    end else if ((fetch_word[6:0] == 7'b1100011) && bht_rd[1]) begin
      pred_tk = 1'b1;
      pred_pc = pc_q + b_imm;
    end
  end

  assign issue = rdy && hit && !stall && (!inst_valid || inst_ready) && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    miss_start = 1'b0;
    fill       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!hit && !redirect_valid) begin
          miss_start = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lowest invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    victim = rr_q[fill_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) victim = WAY_W'(w);
    end
    if (WAYS == 1) victim = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      pred_taken <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (rdy) begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q       <= redirect_pc;
        inst_valid <= 1'b0;
      end else if (issue) begin
        inst_valid <= 1'b1;
        inst       <= fetch_word;
        inst_pc    <= pc_q;
        pred_taken <= pred_tk;
        pc_q       <= pred_pc;
      end else if (inst_ready) begin
        inst_valid <= 1'b0;
      end
      if (miss_start) begin
        mem_req  <= 1'b1;
        mem_addr <= {pc_q[31:OFF_W], {OFF_W{1'b0}}};
      end
      if (fill) begin
        mem_req                   <= 1'b0;
        valid_q[fill_idx][victim] <= 1'b1;
        rr_q[fill_idx]            <= rr_q[fill_idx] + WAY_W'(1);
      end
    end
  end

  // Line storage carries no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      data_q[victim][fill_idx] <= mem_resp_data;
      tag_q[victim][fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (rdy && upd_valid) begin
      if (upd_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      redirect_cnt <= '0;
    end else begin
      if (issue) hit_cnt <= hit_cnt + 32'd1;
      if (rdy && miss_start) miss_cnt <= miss_cnt + 32'd1;
      if (rdy && redirect_valid) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
